// File: rtl/pack_sched.sv
// pack_sched: two-channel round-robin scheduler that feeds whole groups of
// STAGES words from one requester into a downstream packer, then waits for the
// packer's group-complete strobe.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   ch0_data/ch1_data      requester words (ELE_WIDTH)
//   ch0_vld/ch1_vld        requester valid (held with stable data until ready)
//   ch0_rdy/ch1_rdy        ready back to the requesters (combinational)
//   pk_data, pk_vld        word and one-cycle strobe to the packer
//   pk_rst_n               registered synchronous active-low clear to the packer
//   pk_out_vld             packer group-complete strobe
//   grp_vld, grp_ch        one-cycle group-done pulse and owning channel
//   abort_cnt              saturating count of aborted groups
//   pk_err                 sticky flag: packer never signalled completion
//   busy                   scheduler is not idle
module pack_sched #(
  parameter int ELE_WIDTH = 32,
  parameter int STAGES    = 4,    // 2..16
  parameter int TIMEOUT   = 255   // 1..255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ELE_WIDTH-1:0] ch0_data,
  input  logic [ELE_WIDTH-1:0] ch1_data,
  input  logic                 ch0_vld,
  input  logic                 ch1_vld,
  output logic                 ch0_rdy,
  output logic                 ch1_rdy,
  output logic [ELE_WIDTH-1:0] pk_data,
  output logic                 pk_vld,
  output logic                 pk_rst_n,
  input  logic                 pk_out_vld,
  output logic                 grp_vld,
  output logic                 grp_ch,
  output logic [7:0]           abort_cnt,
  output logic                 pk_err,
  output logic                 busy
);

  localparam int WCW = $clog2(STAGES);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_OUT, ABORT} state_e;

  state_e                 state_q;
  logic                   owner_q;
  logic                   last_owner_q;
  logic [WCW-1:0]         word_cnt_q;
  logic [7:0]             stall_cnt_q;
  logic [1:0]             wait_cnt_q;
  logic [ELE_WIDTH-1:0]   pk_data_q;
  logic                   pk_vld_q;
  logic                   pk_rst_n_q;
  logic                   grp_vld_q;
  logic                   grp_ch_q;
  logic [7:0]             abort_cnt_q;
  logic                   pk_err_q;

  logic                   owner_vld;
  logic [ELE_WIDTH-1:0]   owner_data;
  logic                   req_owner;
  logic [7:0]             stall_cnt_d;

  assign owner_vld   = owner_q ? ch1_vld  : ch0_vld;
  assign owner_data  = owner_q ? ch1_data : ch0_data;
  assign stall_cnt_d = stall_cnt_q + 8'd1;

  // On a tie the channel that did not own the previous group wins.
  assign req_owner = (ch0_vld && ch1_vld) ? ~last_owner_q : ch1_vld;

  assign ch0_rdy = (state_q == GRANT) && !owner_q;
  assign ch1_rdy = (state_q == GRANT) &&  owner_q;

  assign pk_data   = pk_data_q;
  assign pk_vld    = pk_vld_q;
  assign pk_rst_n  = pk_rst_n_q;
  assign grp_vld   = grp_vld_q;
  assign grp_ch    = grp_ch_q;
  assign abort_cnt = abort_cnt_q;
  assign pk_err    = pk_err_q;
  assign busy      = (state_q != IDLE);

  // NOTE: every register here is assigned with <=, so each branch reads the
  // values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      word_cnt_q   <= '0;
      stall_cnt_q  <= '0;
      wait_cnt_q   <= '0;
      pk_data_q    <= '0;
      pk_vld_q     <= 1'b0;
      pk_rst_n_q   <= 1'b0;
      grp_vld_q    <= 1'b0;
      grp_ch_q     <= 1'b0;
      abort_cnt_q  <= '0;
      pk_err_q     <= 1'b0;
    end else begin
      // NOTE: strobes default to their idle level each cycle and are only
      // raised by the branch that needs them, so they last exactly one cycle.
      pk_vld_q   <= 1'b0;
      grp_vld_q  <= 1'b0;
      pk_rst_n_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (ch0_vld || ch1_vld) begin
            owner_q     <= req_owner;
            word_cnt_q  <= '0;
            stall_cnt_q <= '0;
            state_q     <= GRANT;
          end
        end

        GRANT: begin
          // A handshake takes priority over a timeout landing on the same edge.
          if (owner_vld) begin
            pk_data_q   <= owner_data;
            pk_vld_q    <= 1'b1;
            word_cnt_q  <= word_cnt_q + WCW'(1);
            stall_cnt_q <= '0;
            if (word_cnt_q == WCW'(STAGES - 1)) begin
              wait_cnt_q <= '0;
              state_q    <= WAIT_OUT;
            end
          end else begin
            stall_cnt_q <= stall_cnt_d;
            if (stall_cnt_d == 8'(TIMEOUT)) begin
              pk_rst_n_q <= 1'b0;
              state_q    <= ABORT;
            end
          end
        end

        WAIT_OUT: begin
          if (pk_out_vld) begin
            grp_vld_q    <= 1'b1;
            grp_ch_q     <= owner_q;
            last_owner_q <= owner_q;
            state_q      <= IDLE;
          end else if (wait_cnt_q == 2'd2) begin
            // Third cycle without completion: the packer is considered lost.
            pk_err_q   <= 1'b1;
            pk_rst_n_q <= 1'b0;
            state_q    <= ABORT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 2'd1;
          end
        end

        ABORT: begin
          if (abort_cnt_q != 8'hFF) abort_cnt_q <= abort_cnt_q + 8'd1;
          last_owner_q <= owner_q;
          state_q      <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
